shift_seq_ctrl: RTL

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/shift_seq_ctrl.sv
// Sequencer for a 4-bit universal shift register.
// Runs load / shift-left / shift-right / rotate-left commands for a programmable count.
module shift_seq_ctrl #(
   parameter int unsigned CNT_W = 3
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             START,
   input  logic             ABORT,
   input  logic [1:0]       MODE,
   input  logic [CNT_W-1:0] CNT,
   input  logic [3:0]       DIN,
   input  logic             SIN,
   input  logic [3:0]       Q_IN,
   output logic [1:0]       S,
   output logic [3:0]       D,
   output logic             SDL,
   output logic             SDR,
   output logic             RCLRb,
   output logic             BUSY,
   output logic             DONE
);

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StFin} state_e;

   state_e           r_state;
   logic [1:0]       r_mode;
   logic [CNT_W-1:0] r_cnt_req;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_din;
   logic [1:0]       r_s;
   logic [3:0]       r_d;
   logic             r_busy;
   logic             r_done;

   logic             w_shift;

   // Outputs are computed together with the next state so they are valid for the whole cycle.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         r_state   <= StIdle;
         r_mode    <= '0;
         r_cnt_req <= '0;
         r_cnt     <= '0;
         r_din     <= '0;
         r_s       <= 2'b00;
         r_d       <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (START && !ABORT) begin
                  r_mode    <= MODE;
                  r_cnt_req <= CNT;
                  r_din     <= DIN;
                  r_state   <= StLoad;
                  r_s       <= 2'b11;
                  r_d       <= DIN;
                  r_busy    <= 1'b1;
               end
            end
            StLoad: begin
               r_d <= '0;
               if (ABORT) begin
                  r_state <= StIdle;
                  r_s     <= 2'b00;
                  r_busy  <= 1'b0;
               end else if (r_mode == 2'b00 || r_cnt_req == '0) begin
                  r_state <= StFin;
                  r_s     <= 2'b00;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= StShift;
                  r_cnt   <= r_cnt_req;
                  r_s     <= (r_mode == 2'b10) ? 2'b01 : 2'b10;
               end
            end
            StShift: begin
               if (ABORT) begin
                  r_state <= StIdle;
                  r_cnt   <= '0;
                  r_s     <= 2'b00;
                  r_busy  <= 1'b0;
               end else if (r_cnt <= 1) begin
                  // Last shift happens on this edge; clamp so the counter never wraps.
                  r_state <= StFin;
                  r_cnt   <= '0;
                  r_s     <= 2'b00;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            StFin: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign w_shift = (r_state == StShift);

   // Serial inputs follow SIN / Q_IN live so the fill bit is never a cycle stale.
   always_comb begin
      SDL = 1'b0;
      SDR = 1'b0;
      if (w_shift) begin
         unique case (r_mode)
            2'b01:   SDL = SIN;
            2'b10:   SDR = SIN;
            2'b11:   SDL = Q_IN[3];
            default: ;
         endcase
      end
   end

   assign S     = r_s;
   assign D     = r_d;
   assign BUSY  = r_busy;
   assign DONE  = r_done;
   assign RCLRb = ~CLR;

endmodule
